// File: rtl/agc_gain_control.sv
// Closed-loop AGC: scales I/Q by a gain register adapted from windowed |I|+|Q|.
// Optional lock indicator built when AGC_LOCK_DETECT_EN is defined.
module agc_gain_control #(
  parameter int W_IN      = 26,
  parameter int W_MAG     = 27,
  parameter int W_GAIN    = 16,
  parameter int GAIN_FRAC = 12,
  parameter int GAIN_MIN  = 64,
  parameter int GAIN_MAX  = 65535,
  parameter int WIN_LOG2  = 8,
  parameter int MU_SHIFT  = 6
) (
  input  logic                     Clk,
  input  logic                     Rst_n,
  input  logic                     In_valid,
  input  logic signed [W_IN-1:0]   In_i,
  input  logic signed [W_IN-1:0]   In_q,
  input  logic        [W_MAG-1:0]  Mag_in,
  input  logic        [W_MAG-1:0]  Target,
  input  logic                     Freeze,
  input  logic                     Gain_wr,
  input  logic        [W_GAIN-1:0] Gain_wr_data,
  output logic                     Out_valid,
  output logic signed [W_IN-1:0]   Out_i,
  output logic signed [W_IN-1:0]   Out_q,
  output logic        [W_GAIN-1:0] Gain,
  output logic                     Locked
);

  localparam int PW = W_IN + W_GAIN + 1;
  localparam int AW = W_MAG + WIN_LOG2;
  localparam int EW = W_MAG + 1;
  localparam int GW = ((EW > W_GAIN + 1) ? EW : W_GAIN + 1) + 1;

  localparam logic signed [PW:0] RND  = (PW+1)'(1) <<< (GAIN_FRAC - 1);
  localparam logic signed [PW:0] OMAX = ((PW+1)'(1) <<< (W_IN - 1)) - 1;
  localparam logic signed [PW:0] OMIN = -OMAX - 1;
  localparam logic signed [GW-1:0] GMIN = GW'(GAIN_MIN);
  localparam logic signed [GW-1:0] GMAX = GW'(GAIN_MAX);

  typedef enum logic {ACCUM, UPDATE} state_t;

  state_t                 state;
  logic                   v1;
  logic signed [PW-1:0]   p_i;
  logic signed [PW-1:0]   p_q;
  logic [AW-1:0]          acc;
  logic [AW-1:0]          sum;
  logic [WIN_LOG2-1:0]    cnt;
  logic [W_MAG-1:0]       avg_r;
  logic signed [EW-1:0]   err;
  logic signed [GW-1:0]   g;
  logic [W_GAIN-1:0]      g_clamp;

  function automatic logic signed [W_IN-1:0] round_sat(
    input logic signed [PW-1:0] p
  );
    logic signed [PW:0] r;
    r = $signed({p[PW-1], p}) + RND;
    r = r >>> GAIN_FRAC;
    if (r > OMAX)      return OMAX[W_IN-1:0];
    else if (r < OMIN) return OMIN[W_IN-1:0];
    else               return r[W_IN-1:0];
  endfunction

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      v1        <= 1'b0;
      p_i       <= '0;
      p_q       <= '0;
      Out_valid <= 1'b0;
      Out_i     <= '0;
      Out_q     <= '0;
    end else begin
      v1        <= In_valid;
      Out_valid <= v1;
      if (In_valid) begin
        p_i <= PW'(In_i) * PW'($signed({1'b0, Gain}));
        p_q <= PW'(In_q) * PW'($signed({1'b0, Gain}));
      end
      if (v1) begin
        Out_i <= round_sat(p_i);
        Out_q <= round_sat(p_q);
      end
    end
  end

  assign sum = acc + AW'(Mag_in);
  assign err = $signed({1'b0, Target}) - $signed({1'b0, avg_r});
  assign g   = $signed(GW'({1'b0, Gain})) + GW'(err >>> MU_SHIFT);

  always_comb begin
    g_clamp = g[W_GAIN-1:0];
    if (g < GMIN)      g_clamp = W_GAIN'(GAIN_MIN);
    else if (g > GMAX) g_clamp = W_GAIN'(GAIN_MAX);
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state <= ACCUM;
      Gain  <= W_GAIN'(1 << GAIN_FRAC);
      acc   <= '0;
      cnt   <= '0;
      avg_r <= '0;
    end else if (Gain_wr) begin
      state <= ACCUM;
      Gain  <= Gain_wr_data;
      acc   <= '0;
      cnt   <= '0;
    end else begin
      unique case (state)
        ACCUM: begin
          if (In_valid) begin
            if (cnt == '1) begin
              avg_r <= W_MAG'(sum >> WIN_LOG2);
              acc   <= '0;
              cnt   <= '0;
              state <= UPDATE;
            end else begin
              acc <= sum;
              cnt <= cnt + 1'b1;
            end
          end
        end
        UPDATE: begin
          if (!Freeze) Gain <= g_clamp;
          // a sample arriving now opens the next window
          if (In_valid) begin
            acc <= AW'(Mag_in);
            cnt <= WIN_LOG2'(1);
          end
          state <= ACCUM;
        end
        default: state <= ACCUM;
      endcase
    end
  end

`ifdef AGC_LOCK_DETECT_EN
  logic [1:0]    lock_cnt;
  logic [1:0]    lock_nxt;
  logic [EW-1:0] abs_err;
  logic          in_tol;

  assign abs_err = err[EW-1] ? EW'(-err) : EW'(err);
  assign in_tol  = abs_err <= EW'(Target >> 4);

  always_comb begin
    lock_nxt = lock_cnt;
    if (Gain_wr)
      lock_nxt = 2'd0;
    else if (state == UPDATE)
      lock_nxt = in_tol ? ((lock_cnt == 2'd3) ? 2'd3 : lock_cnt + 2'd1) : 2'd0;
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      lock_cnt <= 2'd0;
      Locked   <= 1'b0;
    end else begin
      lock_cnt <= lock_nxt;
      Locked   <= (lock_nxt == 2'd3);
    end
  end
`else
  assign Locked = 1'b0;
`endif

endmodule
